// File: rtl/ctrl_pipe_param_if.sv
// Control-pipeline bundle: decoded inputs from Decode, per-stage stall/flush,
// and the per-stage control outputs, flags and PC-write status.
interface ctrl_pipe_param_if #(
    parameter int STAGES     = 3,
    parameter int CTRL_WIDTH = 8
);
    logic [3:0]                   CondD;
    logic [CTRL_WIDTH-1:0]        CtrlD;
    logic                         RegWriteD;
    logic                         MemWriteD;
    logic                         PCSrcD;
    logic                         BranchD;
    logic [1:0]                   FlagWriteD;
    logic [3:0]                   ALUFlagsE;
    logic [STAGES-1:0]            Stall;
    logic [STAGES-1:0]            Flush;
    logic [STAGES*CTRL_WIDTH-1:0] CtrlQ;
    logic [STAGES-1:0]            RegWriteQ;
    logic [STAGES-1:0]            MemWriteQ;
    logic [STAGES-1:0]            PCSrcQ;
    logic                         CondExE;
    logic                         BranchTakenE;
    logic [3:0]                   FlagsE;
    logic                         CarryE;
    logic                         PCWrPendingF;

    modport master (
        output CondD, CtrlD, RegWriteD, MemWriteD, PCSrcD, BranchD, FlagWriteD,
               ALUFlagsE, Stall, Flush,
        input  CtrlQ, RegWriteQ, MemWriteQ, PCSrcQ, CondExE, BranchTakenE,
               FlagsE, CarryE, PCWrPendingF
    );

    modport slave (
        input  CondD, CtrlD, RegWriteD, MemWriteD, PCSrcD, BranchD, FlagWriteD,
               ALUFlagsE, Stall, Flush,
        output CtrlQ, RegWriteQ, MemWriteQ, PCSrcQ, CondExE, BranchTakenE,
               FlagsE, CarryE, PCWrPendingF
    );
endinterface

// File: rtl/ctrl_pipe_param.sv
// Parametrised back-end control pipeline with per-stage stall/flush, NZCV flag
// register and ARM condition evaluation in stage E.
module ctrl_pipe_param #(
    parameter int STAGES     = 3,
    parameter int CTRL_WIDTH = 8
) (
    input logic           clk,
    input logic           reset,
    ctrl_pipe_param_if.slave bus
);
    // Common stage word layout: {ctrl, regWrite, memWrite, pcSrc}
    localparam int WORD = CTRL_WIDTH + 3;
    typedef logic [WORD-1:0] word_t;

    word_t      stageQ   [STAGES];
    word_t      stageSrc [STAGES];
    logic [3:0] cond0Reg;
    logic       branch0Reg;
    logic [1:0] flagWrite0Reg;
    logic [3:0] flagsReg;
    logic       condEx;

    wire flagN = flagsReg[3];
    wire flagZ = flagsReg[2];
    wire flagC = flagsReg[1];
    wire flagV = flagsReg[0];

    always_comb begin
        condEx = 1'b0;
        case (cond0Reg)
            4'd0:    condEx = flagZ;
            4'd1:    condEx = !flagZ;
            4'd2:    condEx = flagC;
            4'd3:    condEx = !flagC;
            4'd4:    condEx = flagN;
            4'd5:    condEx = !flagN;
            4'd6:    condEx = flagV;
            4'd7:    condEx = !flagV;
            4'd8:    condEx = flagC & !flagZ;
            4'd9:    condEx = !flagC | flagZ;
            4'd10:   condEx = (flagN == flagV);
            4'd11:   condEx = (flagN != flagV);
            4'd12:   condEx = !flagZ & (flagN == flagV);
            4'd13:   condEx = flagZ | (flagN != flagV);
            default: condEx = 1'b1;
        endcase
    end

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            word_t wordReg;
            logic  bubble;

            if (gi == 0) begin : g_src
                assign stageSrc[gi] = {bus.CtrlD, bus.RegWriteD, bus.MemWriteD, bus.PCSrcD};
                assign bubble       = 1'b0;
            end else if (gi == 1) begin : g_src
                // Stage 1 receives the condition-gated write controls
                assign stageSrc[gi] = {stageQ[0][WORD-1:3], stageQ[0][2:0] & {3{condEx}}};
                assign bubble       = bus.Stall[gi-1];
            end else begin : g_src
                assign stageSrc[gi] = stageQ[gi-1];
                assign bubble       = bus.Stall[gi-1];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wordReg <= '0;
                end else if (bus.Flush[gi]) begin
                    wordReg <= '0;
                end else if (!bus.Stall[gi]) begin
                    wordReg <= bubble ? '0 : stageSrc[gi];
                end
            end

            assign stageQ[gi] = wordReg;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond0Reg      <= '0;
            branch0Reg    <= 1'b0;
            flagWrite0Reg <= '0;
        end else if (bus.Flush[0]) begin
            cond0Reg      <= '0;
            branch0Reg    <= 1'b0;
            flagWrite0Reg <= '0;
        end else if (!bus.Stall[0]) begin
            cond0Reg      <= bus.CondD;
            branch0Reg    <= bus.BranchD;
            flagWrite0Reg <= bus.FlagWriteD;
        end
    end

    // Flags commit only when the E instruction actually leaves E this edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flagsReg <= '0;
        end else if (condEx && !bus.Stall[0] && !bus.Flush[0]) begin
            if (flagWrite0Reg[1]) flagsReg[3:2] <= bus.ALUFlagsE[3:2];
            if (flagWrite0Reg[0]) flagsReg[1:0] <= bus.ALUFlagsE[1:0];
        end
    end

    logic [STAGES-1:0] pcSrcQ;

    always_comb begin
        bus.CtrlQ     = '0;
        bus.RegWriteQ = '0;
        bus.MemWriteQ = '0;
        pcSrcQ        = '0;
        for (int k = 0; k < STAGES; k++) begin
            bus.CtrlQ[k*CTRL_WIDTH +: CTRL_WIDTH] = stageQ[k][WORD-1:3];
            bus.RegWriteQ[k] = stageQ[k][2];
            bus.MemWriteQ[k] = stageQ[k][1];
            pcSrcQ[k]        = stageQ[k][0];
        end
        bus.RegWriteQ[0] = stageQ[0][2] & condEx;
        bus.MemWriteQ[0] = stageQ[0][1] & condEx;
        pcSrcQ[0]        = stageQ[0][0] & condEx;
    end

    assign bus.PCSrcQ       = pcSrcQ;
    assign bus.CondExE      = condEx;
    assign bus.BranchTakenE = branch0Reg & condEx;
    assign bus.FlagsE       = flagsReg;
    assign bus.CarryE       = flagsReg[1];
    // The final stage performs the PC write itself, so it is not pending
    assign bus.PCWrPendingF = bus.PCSrcD | (|pcSrcQ[STAGES-2:0]);

endmodule

// File: tb/tb_ctrl_pipe_param.sv
// Self-checking bench for ctrl_pipe_param: directed steps followed by random
// traffic compared against a bundle-level pipeline model.
module tb_ctrl_pipe_param;
    localparam int S = 3;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ctrl_pipe_param_if #(.STAGES(S), .CTRL_WIDTH(W)) bus ();

    ctrl_pipe_param #(.STAGES(S), .CTRL_WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]   cond;
        logic [W-1:0] ctrl;
        logic         rw;
        logic         mw;
        logic         pc;
        logic         br;
        logic [1:0]   fw;
    } bundle_t;

    bundle_t    mSt [S];
    logic [3:0] mFlags;

    // Condition field: upper three bits choose a test, bit 0 inverts it
    function automatic logic condPass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < S; k++) mSt[k] = '0;
        mFlags = '0;
    endtask

    task automatic checkAll();
        logic             pass;
        logic [S*W-1:0]   eCtrl;
        logic [S-1:0]     eRw, eMw, ePc;
        pass = condPass(mSt[0].cond, mFlags);
        for (int k = 0; k < S; k++) begin
            eCtrl[k*W +: W] = mSt[k].ctrl;
            eRw[k] = mSt[k].rw;
            eMw[k] = mSt[k].mw;
            ePc[k] = mSt[k].pc;
        end
        eRw[0] = eRw[0] & pass;
        eMw[0] = eMw[0] & pass;
        ePc[0] = ePc[0] & pass;
        chk("CtrlQ",        64'(bus.CtrlQ),        64'(eCtrl));
        chk("RegWriteQ",    64'(bus.RegWriteQ),    64'(eRw));
        chk("MemWriteQ",    64'(bus.MemWriteQ),    64'(eMw));
        chk("PCSrcQ",       64'(bus.PCSrcQ),       64'(ePc));
        chk("CondExE",      64'(bus.CondExE),      64'(pass));
        chk("BranchTakenE", 64'(bus.BranchTakenE), 64'(mSt[0].br & pass));
        chk("FlagsE",       64'(bus.FlagsE),       64'(mFlags));
        chk("CarryE",       64'(bus.CarryE),       64'(mFlags[1]));
        chk("PCWrPendingF", 64'(bus.PCWrPendingF), 64'(bus.PCSrcD | (|ePc[S-2:0])));
    endtask

    // Check the current cycle, advance the model across the next edge
    task automatic cycle();
        bundle_t    nx [S];
        bundle_t    d;
        logic [3:0] nf;
        logic       pass;
        #1;
        checkAll();
        pass = condPass(mSt[0].cond, mFlags);
        d.cond = bus.CondD;   d.ctrl = bus.CtrlD;  d.rw = bus.RegWriteD;
        d.mw = bus.MemWriteD; d.pc = bus.PCSrcD;   d.br = bus.BranchD;
        d.fw = bus.FlagWriteD;
        for (int k = 0; k < S; k++) begin
            if (bus.Flush[k])      nx[k] = '0;
            else if (bus.Stall[k]) nx[k] = mSt[k];
            else if (k == 0)       nx[k] = d;
            else if (bus.Stall[k-1]) nx[k] = '0;
            else begin
                nx[k] = mSt[k-1];
                if (k == 1) begin
                    nx[k].rw = nx[k].rw & pass;
                    nx[k].mw = nx[k].mw & pass;
                    nx[k].pc = nx[k].pc & pass;
                end
            end
        end
        nf = mFlags;
        if (pass && !bus.Stall[0] && !bus.Flush[0]) begin
            if (mSt[0].fw[1]) nf[3:2] = bus.ALUFlagsE[3:2];
            if (mSt[0].fw[0]) nf[1:0] = bus.ALUFlagsE[1:0];
        end
        @(posedge clk);
        for (int k = 0; k < S; k++) mSt[k] = nx[k];
        mFlags = nf;
        #1;
    endtask

    task automatic clearD();
        bus.CondD = '0; bus.CtrlD = '0; bus.RegWriteD = 1'b0; bus.MemWriteD = 1'b0;
        bus.PCSrcD = 1'b0; bus.BranchD = 1'b0; bus.FlagWriteD = '0;
        bus.ALUFlagsE = '0; bus.Stall = '0; bus.Flush = '0;
    endtask

    task automatic asyncReset();
        clearD();
        reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        chk("async_rst_flags", 64'(bus.FlagsE), 64'(0));
        reset = 1'b0;
    endtask

    initial begin
        clearD();
        modelReset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset then idle
        #1;
        chk("rst_ctrl",  64'(bus.CtrlQ),        64'(0));
        chk("rst_rw",    64'(bus.RegWriteQ),    64'(0));
        chk("rst_condx", 64'(bus.CondExE),      64'(0));
        chk("rst_pend",  64'(bus.PCWrPendingF), 64'(0));
        cycle();

        // Basic latency
        bus.CondD = 4'd14; bus.RegWriteD = 1'b1; bus.CtrlD = 8'hA5;
        cycle();
        chk("rw0_after1", 64'(bus.RegWriteQ[0]), 64'(1));
        clearD();
        cycle();
        cycle();
        chk("ctrl_s2_after3", 64'(bus.CtrlQ[2*W +: W]), 64'(8'hA5));

        // Flag write then EQ consumer
        clearD(); bus.CondD = 4'd14; bus.FlagWriteD = 2'b11;
        cycle();
        clearD(); bus.ALUFlagsE = 4'b0100; bus.CondD = 4'd0; bus.RegWriteD = 1'b1;
        cycle();
        chk("flags_0100", 64'(bus.FlagsE), 64'(4'b0100));
        chk("eq_condex",  64'(bus.CondExE), 64'(1));
        clearD();
        cycle();
        chk("eq_rw1", 64'(bus.RegWriteQ[1]), 64'(1));

        // Same with NE consumer
        clearD(); bus.CondD = 4'd14; bus.FlagWriteD = 2'b11;
        cycle();
        clearD(); bus.ALUFlagsE = 4'b0100; bus.CondD = 4'd1; bus.RegWriteD = 1'b1;
        cycle();
        chk("ne_condex", 64'(bus.CondExE), 64'(0));
        clearD();
        cycle();
        chk("ne_rw1", 64'(bus.RegWriteQ[1]), 64'(0));

        // Partial flag write keeps C,V
        clearD(); bus.CondD = 4'd14; bus.FlagWriteD = 2'b10;
        cycle();
        clearD(); bus.ALUFlagsE = 4'b1011;
        cycle();
        chk("flags_nz_only", 64'(bus.FlagsE), 64'(4'b1000));
        chk("carry_kept",    64'(bus.CarryE), 64'(0));

        // Stall stage 0 for two cycles with a store in E
        clearD(); bus.CondD = 4'd14; bus.MemWriteD = 1'b1;
        cycle();
        clearD(); bus.Stall = 3'b001;
        cycle();
        chk("stall_mw1_a", 64'(bus.MemWriteQ[1]), 64'(0));
        chk("stall_mw0_a", 64'(bus.MemWriteQ[0]), 64'(1));
        cycle();
        chk("stall_mw1_b", 64'(bus.MemWriteQ[1]), 64'(0));
        clearD();
        cycle();
        chk("release_mw1", 64'(bus.MemWriteQ[1]), 64'(1));
        cycle();
        chk("release_once", 64'(bus.MemWriteQ[1]), 64'(0));

        // Flush beats stall; flags untouched
        clearD(); bus.CondD = 4'd14; bus.BranchD = 1'b1; bus.FlagWriteD = 2'b11;
        cycle();
        chk("br_taken", 64'(bus.BranchTakenE), 64'(1));
        clearD(); bus.Stall = 3'b001; bus.Flush = 3'b001; bus.ALUFlagsE = 4'b1111;
        cycle();
        chk("flush_br",    64'(bus.BranchTakenE), 64'(0));
        chk("flush_flags", 64'(bus.FlagsE),       64'(4'b1000));

        // PC write pending window
        clearD(); bus.CondD = 4'd14; bus.PCSrcD = 1'b1;
        for (int c = 0; c <= S; c++) begin
            #1;
            chk($sformatf("pend_%0d", c), 64'(bus.PCWrPendingF), 64'(c < S));
            cycle();
            clearD();
        end

        // Random traffic with occasional asynchronous reset
        for (int i = 0; i < 400; i++) begin
            logic [S-1:0] st, fl;
            if (i % 97 == 50) asyncReset();
            for (int k = 0; k < S; k++) begin
                st[k] = ($urandom_range(0, 4) == 0);
                fl[k] = ($urandom_range(0, 7) == 0);
            end
            bus.CondD      = 4'($urandom);
            bus.CtrlD      = W'($urandom);
            bus.RegWriteD  = 1'($urandom);
            bus.MemWriteD  = 1'($urandom);
            bus.PCSrcD     = ($urandom_range(0, 3) == 0);
            bus.BranchD    = 1'($urandom);
            bus.FlagWriteD = 2'($urandom);
            bus.ALUFlagsE  = 4'($urandom);
            bus.Stall      = st;
            bus.Flush      = fl;
            cycle();
        end
        clearD();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe_param.md
# ctrl_pipe_param

Parametrised control-bundle pipeline carrying decoded control bits from Decode through STAGES back-end stages (E, M, W, … for the default depth) with per-stage stall and flush. It holds the NZCV flag register, evaluates the 4-bit ARM condition field in stage E, gates the write-type controls by the result, and reports whether a PC write is still in flight. It replaces fixed three-stage control registers and adds stall/bubble handling, generic passthrough bits and configurable depth.

## Interface
- STAGES, 3: back-end stages; index 0 = E, STAGES-1 = W; legal range 2..8.
- CTRL_WIDTH, 8: generic passthrough bits per stage, such as ALUControl and MemtoReg; legal range 1..32.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- CondD  in  4  condition field of the instruction in Decode.
- CtrlD  in  CTRL_WIDTH  generic control bits from Decode.
- RegWriteD, MemWriteD, PCSrcD, BranchD  in  1 each  decoded controls.
- FlagWriteD  in  2  [1] updates N,Z; [0] updates C,V.
- ALUFlagsE  in  4  {N,Z,C,V} from the stage-E ALU.
- Stall  in  STAGES  bit k holds stage k.
- Flush  in  STAGES  bit k clears stage k.
- CtrlQ  out  STAGES*CTRL_WIDTH  stage k occupies bits [k*CTRL_WIDTH +: CTRL_WIDTH].
- RegWriteQ, MemWriteQ, PCSrcQ  out  STAGES each  per-stage controls; bit 0 is condition-gated.
- CondExE  out  1  condition passes in stage E.
- BranchTakenE  out  1  BranchE & CondExE.
- FlagsE  out  4  flag register {N,Z,C,V}.
- CarryE  out  1  FlagsE[1].
- PCWrPendingF  out  1  a PC write is in flight.

## Operation
- Stage 0 register holds {Cond, Ctrl, RegWrite, MemWrite, PCSrc, Branch, FlagWrite}. Stages k≥1 hold {Ctrl, RegWrite, MemWrite, PCSrc}.
- Each stage's update, in priority order:
  - Flush[k]: all bits go to 0.
  - Else Stall[k]: the stage holds its value.
  - Else, if k≥1 and Stall[k-1]: the stage loads a bubble (all 0).
  - Else: the stage loads from its source. The source of stage 0 is the D inputs. The source of stage 1 is the gated stage-0 outputs. The source of stage k≥2 is stage k-1.
- Condition decode uses FlagsE:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C.
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V.
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 and 15 always.
- Gating in stage 0:
  - RegWriteQ[0], MemWriteQ[0] and PCSrcQ[0] equal the stage-0 values ANDed with CondExE.
  - BranchTakenE = Branch0 & CondExE.
  - A bubble or flushed stage 0 has all controls 0, so all gated outputs are 0.
- Flag update happens when CondExE & !Stall[0] & !Flush[0]:
  - FlagWrite0[1] loads N,Z from ALUFlagsE.
  - FlagWrite0[0] loads C,V from ALUFlagsE.
  - Otherwise the flags hold.
- PCWrPendingF = PCSrcD | OR of PCSrcQ[0..STAGES-2]. PCSrcQ[0] is gated. The last stage is excluded because it performs the write.

## Timing
- Reset clears every stage register and FlagsE to 0. After reset, all Q outputs, CondExE (Cond=0 EQ with Z=0), BranchTakenE, CarryE and PCWrPendingF are 0.
- Latency: a D bundle appears in stage k k+1 edges after it is presented. Stage-E outputs are combinational from the stage-0 register.
- A flag update is visible in FlagsE one edge after the instruction sits in E. The next instruction in E sees it, so there is no flag-forwarding path.
- Flush and Stall on the same stage in the same cycle: flush wins.
- Stall[k] with Stall[k+1]=0 inserts exactly one bubble per held cycle into stage k+1.
- Reset asserted mid-operation clears state immediately (asynchronous). The first bundle is captured on the first edge after reset deasserts.

## Test plan
- Reset then idle: every output is 0. CondD=14, RegWriteD=1, CtrlD=8'hA5 → RegWriteQ[0]=1 after 1 edge, CtrlQ stage 2 = 8'hA5 after 3 edges.
- Flags: stage 0 with FlagWrite=2'b11 and ALUFlagsE=4'b0100 → FlagsE=4'b0100 next cycle. The next instruction, CondD=0 (EQ) with RegWriteD=1, gets CondExE=1 and RegWriteQ[1]=1. The same test with CondD=1 (NE) gives CondExE=0 and RegWriteQ[1]=0.
- FlagWrite=2'b10 with ALUFlagsE=4'b1011 after FlagsE=4'b0100 → FlagsE=4'b1000 (C,V kept). CarryE=0.
- Stall[0] held for 2 cycles with a MemWrite=1 instruction in E: stage 0 holds, and MemWriteQ[1] is 0 for 2 cycles (bubbles). On release, MemWriteQ[1]=1 exactly once.
- Flush[0] and Stall[0] both asserted → stage 0 is cleared. BranchTakenE=0 and flags are unchanged.
- PCSrcD=1, CondD=14 → PCWrPendingF is 1 from the D cycle through the cycle the instruction sits in stage STAGES-2, and 0 once it reaches W (default: 3 cycles high).
